// File: rtl/mini_pe.sv
// mini_pe: small processing element fed by the per-rank switch.
// Captures changed command bytes addressed to this rank into a small FIFO,
// then executes them one at a time: register loads, a 4-bit ALU and a
// shift-add multiply-accumulate. Each result is emitted on res_out with a
// toggling bit 7, so that the switch sees a change even if the value repeats.
module mini_pe #(
  parameter logic [1:0] RANK       = 2'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_in,
  output logic [7:0] res_out,
  output logic       busy,
  output logic       overflow
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, EMIT} state_t;

  // The FIFO and cmd_reg hold only {opcode, operand}. The rank field has
  // already been matched at capture and is not needed after that.
  logic [5:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    prev_cmd;

  state_t     state;
  logic [5:0] cmd_reg;
  logic [3:0] a_reg, b_reg, res;
  logic [7:0] prod, acc;
  logic [1:0] cnt;

  logic       is_new, for_me, full, empty, push, pop;
  logic [3:0] alu_res;
  logic [7:0] partial, prod_next, acc_next;

  assign is_new = (cmd_in != prev_cmd);
  assign for_me = (cmd_in[5:4] == RANK);
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign push   = is_new && for_me && !full;
  assign pop    = (state == IDLE) && !empty;
  assign busy   = (state != IDLE) || !empty;

  // ALU result and one shift-add step of the multiplier.
  always_comb begin
    // NOTE: give every always_comb output a default first so that no path leaves it unassigned and infers a latch.
    alu_res = 4'h0;
    case (cmd_reg[1:0])
      2'b00: alu_res = a_reg + b_reg;
      2'b01: alu_res = a_reg - b_reg;
      2'b10: alu_res = a_reg & b_reg;
      2'b11: alu_res = a_reg ^ b_reg;
      default: alu_res = 4'h0;
    endcase
    partial   = b_reg[cnt] ? ({4'h0, a_reg} << cnt) : 8'h00;
    prod_next = prod + partial;
    acc_next  = acc + prod_next;
  end

  // FIFO storage. It is left unreset because the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    // NOTE: memory arrays get no reset; the reset pointers/count make stale contents unreachable.
    if (push) fifo_mem[wr_ptr] <= {cmd_in[7:6], cmd_in[3:0]};
  end

  // Change-detect capture, FIFO pointers/occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cmd <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      prev_cmd <= cmd_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (is_new && for_me && full) overflow <= 1'b1;
    end
  end

  // Execute FSM: pop, decode/execute, multi-cycle multiply, emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_reg <= 6'h00;
      a_reg   <= 4'h0;
      b_reg   <= 4'h0;
      prod    <= 8'h00;
      acc     <= 8'h00;
      cnt     <= 2'd0;
      res     <= 4'h0;
      res_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            cmd_reg <= fifo_mem[rd_ptr];
            state   <= EXEC;
          end
        end
        EXEC: begin
          case (cmd_reg[5:4])
            2'b00: begin
              a_reg <= cmd_reg[3:0];
              state <= IDLE;
            end
            2'b01: begin
              b_reg <= cmd_reg[3:0];
              state <= IDLE;
            end
            2'b10: begin
              res   <= alu_res;
              state <= EMIT;
            end
            default: begin
              if (cmd_reg[0]) acc <= 8'h00;
              prod  <= 8'h00;
              cnt   <= 2'd0;
              state <= MUL;
            end
          endcase
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            acc   <= acc_next;
            res   <= cmd_reg[1] ? acc_next[7:4] : acc_next[3:0];
            state <= EMIT;
          end
        end
        EMIT: begin
          res_out <= {~res_out[7], 3'b000, res};
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_pe.sv
// tb_mini_pe: scoreboard bench for mini_pe (RANK=0).
// A reference model predicts each result and its arrival edge when a command
// is driven. A monitor pops and compares the prediction whenever res_out changes.
module tb_mini_pe;

  typedef struct {
    logic [7:0] val;
    int         at_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_in;
  logic [7:0] res_out;
  logic       busy;
  logic       overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic rst_q    = 1'b1;
  logic [7:0] last_res = 8'h00;
  exp_t sb_q[$];

  // reference model state
  logic [3:0] m_a, m_b;
  logic [7:0] m_acc;
  logic       m_tog;

  mini_pe #(.RANK(2'd0), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_in   (cmd_in),
    .res_out  (res_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: each change of res_out outside reset must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_q) begin
      last_res = res_out;
    end else if (res_out !== last_res) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res", res_out, last_res);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_val", res_out, e.val);
        check("res_edge", cyc, e.at_edge);
      end
      last_res = res_out;
    end
  end

  task automatic model_reset();
    m_a = 4'h0; m_b = 4'h0; m_acc = 8'h00; m_tog = 1'b0;
  endtask

  // Called right after a clock edge. The byte is captured on the next edge.
  // When accept is set, the model applies the command and queues any expected result.
  task automatic drive(input logic [7:0] c, input bit accept);
    int         cap;
    logic [3:0] r;
    logic [7:0] pa, pb;
    exp_t       e;
    cmd_in = c;
    cap    = cyc + 1;
    if (accept && c[5:4] == 2'b00) begin
      case (c[7:6])
        2'b00: m_a = c[3:0];
        2'b01: m_b = c[3:0];
        2'b10: begin
          case (c[1:0])
            2'b00: r = m_a + m_b;
            2'b01: r = m_a - m_b;
            2'b10: r = m_a & m_b;
            default: r = m_a ^ m_b;
          endcase
          m_tog = ~m_tog;
          e.val = {m_tog, 3'b000, r};
          e.at_edge = cap + 3;
          sb_q.push_back(e);
        end
        default: begin
          pa = {4'h0, m_a};
          pb = {4'h0, m_b};
          if (c[0]) m_acc = 8'h00;
          m_acc = m_acc + pa * pb;
          r = c[1] ? m_acc[7:4] : m_acc[3:0];
          m_tog = ~m_tog;
          e.val = {m_tog, 3'b000, r};
          e.at_edge = cap + 7;
          sb_q.push_back(e);
        end
      endcase
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst    = 1'b1;
    cmd_in = 8'h00;
    step(3);
    check("rst_res_out", res_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    step(2);

    // 1: loads then ADD -> 0x88
    drive(8'h03, 1); step(5);
    drive(8'h45, 1); step(5);
    check("a_after_load", dut.a_reg, m_a);
    check("b_after_load", dut.b_reg, m_b);
    drive(8'h80, 1); step(5);

    // 2: SUB and AND
    drive(8'h81, 1); step(5);
    drive(8'h82, 1); step(5);
    check("res_after_and", res_out, 8'h81);

    // 3: clear+MAC, then accumulate
    drive(8'hC1, 1); step(9);
    drive(8'hC2, 1); step(9);
    check("acc_after_mac", dut.acc, m_acc);
    check("acc_is_30", m_acc, 8'd30);

    // 4: other rank ignored
    drive(8'h17, 1); step(1);
    check("other_rank_busy", busy, 1'b0);
    step(3);
    check("other_rank_busy_later", busy, 1'b0);
    check("other_rank_a", dut.a_reg, 4'h3);
    check("other_rank_res", res_out, 8'h81);

    // 5: MAC in flight, five loads back-to-back, last one dropped
    drive(8'hC0, 1); step(1);
    drive(8'h01, 1); step(1);
    drive(8'h02, 1); step(1);
    drive(8'h03, 1); step(1);
    check("busy_during_mac", busy, 1'b1);
    check("no_overflow_yet", overflow, 1'b0);
    drive(8'h04, 1); step(1);
    check("fifo_full", dut.count, 3'd4);
    drive(8'h05, 0); step(1);
    check("overflow_set", overflow, 1'b1);
    step(25);
    check("drained_busy", busy, 1'b0);
    check("overflow_sticky", overflow, 1'b1);
    check("final_a", dut.a_reg, m_a);
    check("final_a_is_4", m_a, 4'h4);

    // 6: reset during MUL with two entries queued
    drive(8'hC0, 1); step(1);
    drive(8'h01, 1); step(1);
    drive(8'h02, 1); step(2);
    check("mul_before_rst_busy", busy, 1'b1);
    rst    = 1'b1;
    cmd_in = 8'h00;
    sb_q.delete();
    model_reset();
    step(1);
    rst = 1'b0;
    check("midrst_res_out", res_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_fifo_empty", dut.count, 3'd0);
    step(3);
    check("post_rst_idle", busy, 1'b0);
    drive(8'h80, 1); step(6);
    check("post_rst_res", res_out, 8'h80);

    step(4);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_pe.md
Name: mini_pe

Overview:
- Processing element sitting directly downstream of the per-rank switch: it consumes the byte stream the switch drives on its PE-facing output.
- Executes 4-bit load/ALU/multiply-accumulate commands on that stream.
- Returns each result to the switch's PE-facing input. The switch re-tags the result with 4'b1111 before forwarding it.
- Includes change-detect capture, a 4-entry command FIFO and a small execute FSM.

Parameters:
RANK, 0, 2-bit PE rank; only command bytes with cmd[5:4] == RANK are executed
FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
cmd_in  input  8  command byte from switch PE output; held stable until next command
res_out  output  8  result byte to switch PE input: {toggle, 3'b000, result[3:0]}
busy  output  1  high when FSM not in IDLE or FIFO non-empty
overflow  output  1  sticky: command lost because FIFO full

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, sampled at a clk edge with rst=1, sets:
  - res_out=0x00, busy=0, overflow=0
  - FIFO empty; prev_cmd=0x00; A=B=0; acc=8'h00; state IDLE
  - Reset mid-operation aborts the command and discards FIFO contents.
- Command byte format:
  - [7:6] opcode
  - [5:4] destination rank
  - [3:0] operand/function
- Capture:
  - A byte is new when cmd_in != prev_cmd at a clock edge; prev_cmd <= cmd_in on that edge.
  - New byte with [5:4] != RANK: discarded, no FIFO write.
  - New byte with [5:4] == RANK: pushed if FIFO not full; otherwise dropped and overflow<=1, which holds until reset.
  - Identical consecutive commands are not seen, by protocol (matches switch change-detect). A 0x00 command directly after reset is not seen.
  - Push and pop on the same edge are both performed; occupancy is unchanged.
- FSM states: IDLE, EXEC, MUL, EMIT.
  - IDLE: if FIFO non-empty, pop head into cmd_reg and go to EXEC.
  - EXEC, by opcode:
    - 00 LOADA: A<=cmd_reg[3:0]; go to IDLE; no output.
    - 01 LOADB: B<=cmd_reg[3:0]; go to IDLE; no output.
    - 10 ALU, function in cmd_reg[1:0]:
      - 00: A+B mod 16
      - 01: A-B mod 16
      - 10: A&B
      - 11: A^B
      - res<=result; go to EMIT.
    - 11 MAC: if cmd_reg[0]=1 clear acc first; prod<=0; cnt<=0; go to MUL.
  - MUL: 4 cycles of shift-add.
    - prod <= prod + (B[cnt] ? A<<cnt : 0); cnt++.
    - On the cycle cnt==3: acc <= acc(or 0 if cleared) + final prod, mod 256.
    - res <= cmd_reg[1] ? new acc[7:4] : new acc[3:0]; go to EMIT.
  - EMIT: res_out <= {~res_out[7], 3'b000, res}; go to IDLE.
    - Bit 7 toggles on every emission, so the switch always detects a change even if the result repeats.
- Latency, measured from the capturing edge k (FIFO empty, FSM idle):
  - Pop at edge k+1.
  - ALU: res_out updates at edge k+3.
  - MAC: MUL occupies edges k+3..k+6; res_out updates at edge k+7.
  - LOADs: register written at edge k+2.
- Throughput: one command in service at a time. Up to FIFO_DEPTH commands are buffered while a MAC executes.
- Widths and stability:
  - A and B are 4 bits; prod and acc are 8 bits; all arithmetic wraps.
  - res_out holds its value between emissions.

Test Plan:
1. RANK=0; after reset drive 0x03, 0x45, 0x80, one change each 5 cycles -> A=3, B=5; res_out=0x88 exactly 3 cycles after 0x80 is captured.
2. Then drive 0x81 (SUB) -> res_out=0x0E (3-5 mod 16, toggle back to 0); then 0x82 -> res_out=0x81 (3&5=1, toggle 1).
3. Then drive 0xC1 (clear+MAC, low nibble) -> res_out=0x0F 7 cycles after capture. Then 0xC2 (accumulate, high nibble) -> acc=30; res_out=0x81 (30>>4=1).
4. Drive 0x17 ([5:4]=01) -> no FIFO write, A unchanged (still 3), res_out unchanged, busy stays 0.
5. Start MAC 0xC0, then present 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles -> first four buffered, 0x05 dropped; overflow=1 and remains set after the FIFO drains; final A=4.
6. Assert rst during MUL with 2 entries queued -> next edge: res_out=0x00, busy=0, overflow=0, FIFO empty; a subsequent 0x80 yields res_out=0x80 (0+0, toggle 1).
